// File: rtl/axis_dwidth_upsizer.sv
// axis_dwidth_upsizer
// AXI4-Stream width upsizer. It packs NUM_REG consecutive WIDTH-bit slave
// beats into one WIDTH*NUM_REG-bit master beat, placing them little-endian:
// the first beat of a word goes in lane 0.
// A beat with tlast set closes the word early. Any unfilled upper lanes of
// that word are driven as zero.
// aresetn is an asynchronous reset and is active HIGH. Its name is kept
// from the existing codebase.
// Optional feature: define AXIS_UPSIZER_TKEEP_EN to add an m_axis_tkeep
// output that marks the filled lanes. This requires WIDTH % 8 == 0.

module axis_dwidth_upsizer #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NUM_REG = 2
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic [WIDTH-1:0]           s_axis_tdata,
   input  logic                       s_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [WIDTH*NUM_REG-1:0]   m_axis_tdata,
   output logic                       m_axis_tlast
`ifdef AXIS_UPSIZER_TKEEP_EN
   ,
   output logic [NUM_REG*WIDTH/8-1:0] m_axis_tkeep
`endif
);

   localparam int unsigned CW   = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
   localparam int unsigned MW   = WIDTH * NUM_REG;
   localparam int unsigned AW   = WIDTH * (NUM_REG - 1);
   localparam logic [CW-1:0] LAST_LANE = CW'(NUM_REG - 1);

   // Lane index of the next slave beat, plus the lanes collected so far.
   // The final lane is never stored here: it goes straight to the output.
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] acc_q, acc_d;

   // Output register
   logic [MW-1:0] data_q, data_d;
   logic          last_q, last_d;
   logic          valid_q, valid_d;

`ifdef AXIS_UPSIZER_TKEEP_EN
   localparam int unsigned LB = WIDTH / 8;
   localparam int unsigned KW = MW / 8;
   logic [KW-1:0] keep_q, keep_d;
   logic [KW-1:0] keep_new;
`endif

   logic          accept;
   logic          complete;
   int unsigned   lane;
   logic [MW-1:0] packed_word;

   assign lane          = 32'(cnt_q);
   assign s_axis_tready = !aresetn && (!valid_q || m_axis_tready);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign complete      = accept && (s_axis_tlast || (cnt_q == LAST_LANE));

   assign m_axis_tvalid = valid_q;
   assign m_axis_tdata  = data_q;
   assign m_axis_tlast  = last_q;
`ifdef AXIS_UPSIZER_TKEEP_EN
   assign m_axis_tkeep  = keep_q;
`endif

   // Build the word to be emitted: lanes below cnt come from the
   // accumulator, lane cnt is the incoming beat, and higher lanes are zero.
   always_comb begin
      packed_word = '0;
      for (int unsigned i = 0; i < NUM_REG - 1; i++) begin
         if (i < lane) begin
            packed_word[i*WIDTH +: WIDTH] = acc_q[i*WIDTH +: WIDTH];
         end
      end
      packed_word[lane*WIDTH +: WIDTH] = s_axis_tdata;
   end

`ifdef AXIS_UPSIZER_TKEEP_EN
   // Byte enables cover lanes 0..cnt of the word being emitted.
   always_comb begin
      keep_new = '0;
      for (int unsigned i = 0; i < NUM_REG; i++) begin
         if (i <= lane) begin
            keep_new[i*LB +: LB] = '1;
         end
      end
   end
`endif

   // Next-state logic. A completing beat overrides a drain in the same
   // cycle, so the new word replaces the old one and valid stays high.
   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      data_d  = data_q;
      last_d  = last_q;
      valid_d = valid_q;
`ifdef AXIS_UPSIZER_TKEEP_EN
      keep_d  = keep_q;
`endif

      if (valid_q && m_axis_tready) begin
         valid_d = 1'b0;
      end

      if (complete) begin
         data_d  = packed_word;
         last_d  = s_axis_tlast;
         valid_d = 1'b1;
         cnt_d   = '0;
         acc_d   = '0;
`ifdef AXIS_UPSIZER_TKEEP_EN
         keep_d  = keep_new;
`endif
      end else if (accept) begin
         acc_d[lane*WIDTH +: WIDTH] = s_axis_tdata;
         cnt_d                      = cnt_q + 1'b1;
      end
   end

   // State registers. Reset discards any partial and any pending word.
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
`ifdef AXIS_UPSIZER_TKEEP_EN
         keep_q  <= '0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         last_q  <= last_d;
         valid_q <= valid_d;
`ifdef AXIS_UPSIZER_TKEEP_EN
         keep_q  <= keep_d;
`endif
      end
   end

endmodule

// File: tb/tb_axis_dwidth_upsizer.sv
// Self-checking bench for axis_dwidth_upsizer.
// It runs directed scenarios followed by randomized traffic. The results
// are compared against a queue-based packing model.
// Build with AXIS_UPSIZER_TKEEP_EN defined to also exercise tkeep.

module tb_axis_dwidth_upsizer;

   localparam int unsigned W  = 32;
   localparam int unsigned N  = 2;
   localparam int unsigned MW = W * N;

   logic           aclk = 1'b0;
   logic           aresetn;
   logic           s_tvalid;
   logic           s_tready;
   logic [W-1:0]   s_tdata;
   logic           s_tlast;
   logic           m_tvalid;
   logic           m_tready;
   logic [MW-1:0]  m_tdata;
   logic           m_tlast;
`ifdef AXIS_UPSIZER_TKEEP_EN
   logic [MW/8-1:0] m_tkeep;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      logic [MW-1:0] data;
      logic          last;
      int unsigned   nbeats;
   } word_t;

   logic [W-1:0] part[$];
   word_t        expq[$];

   axis_dwidth_upsizer #(.WIDTH(W), .NUM_REG(N)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tlast  (s_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tlast  (m_tlast)
`ifdef AXIS_UPSIZER_TKEEP_EN
      ,
      .m_axis_tkeep  (m_tkeep)
`endif
   );

   always #5 aclk = ~aclk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: collect beats; a word is closed by tlast or by filling N beats.
   task automatic model_accept(input logic [W-1:0] d, input logic lst);
      word_t w;
      part.push_back(d);
      if (lst || part.size() == N) begin
         w.data   = '0;
         w.nbeats = part.size();
         for (int i = 0; i < part.size(); i++) begin
            w.data = w.data | (MW'(part[i]) << (i * W));
         end
         w.last = lst;
         expq.push_back(w);
         part.delete();
      end
   endtask

   function automatic logic [MW/8-1:0] keep_of(input int unsigned nbeats);
      logic [MW/8-1:0] k;
      k = '0;
      for (int i = 0; i < nbeats * (W / 8); i++) k[i] = 1'b1;
      return k;
   endfunction

   // One clock cycle: drive inputs at the falling edge, then check the outputs
   // and advance the model with the handshakes that the next rising edge commits.
   task automatic step(input logic vld, input logic [W-1:0] d, input logic lst, input logic rdy);
      logic exp_rdy;
      @(negedge aclk);
      s_tvalid = vld;
      s_tdata  = d;
      s_tlast  = lst;
      m_tready = rdy;
      #1;
      exp_rdy = (expq.size() == 0) || rdy;
      check_eq("s_tready", s_tready, exp_rdy);
      check_eq("m_tvalid", m_tvalid, expq.size() != 0);
      if (expq.size() != 0) begin
         check_eq("m_tdata", m_tdata, expq[0].data);
         check_eq("m_tlast", m_tlast, expq[0].last);
`ifdef AXIS_UPSIZER_TKEEP_EN
         check_eq("m_tkeep", m_tkeep, keep_of(expq[0].nbeats));
`endif
         if (rdy) void'(expq.pop_front());
      end
      if (vld && exp_rdy) model_accept(d, lst);
   endtask

   task automatic apply_reset();
      @(negedge aclk);
      #2;
      aresetn  = 1'b1;
      s_tvalid = 1'b0;
      #1;
      check_eq("rst_tvalid", m_tvalid, 1'b0);
      check_eq("rst_tdata", m_tdata, '0);
      check_eq("rst_tlast", m_tlast, 1'b0);
      check_eq("rst_tready", s_tready, 1'b0);
`ifdef AXIS_UPSIZER_TKEEP_EN
      check_eq("rst_tkeep", m_tkeep, '0);
`endif
      part.delete();
      expq.delete();
      repeat (2) @(negedge aclk);
      aresetn = 1'b0;
   endtask

   initial begin
      aresetn  = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tlast  = 1'b0;
      m_tready = 1'b0;
      #3;
      check_eq("init_tvalid", m_tvalid, 1'b0);
      check_eq("init_tdata", m_tdata, '0);
      check_eq("init_tready", s_tready, 1'b0);
      repeat (2) @(negedge aclk);
      aresetn = 1'b0;

      // Full pack
      step(1'b1, 32'h64, 1'b0, 1'b1);
      step(1'b1, 32'h74, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      check_eq("pack_data", m_tdata, 64'h00000074_00000064);
      check_eq("pack_last", m_tlast, 1'b0);
      check_eq("pack_valid", m_tvalid, 1'b1);

      // Continuous stream
      step(1'b1, 32'h64, 1'b0, 1'b1);
      check_eq("cont_rdy0", s_tready, 1'b1);
      step(1'b1, 32'h74, 1'b0, 1'b1);
      check_eq("cont_rdy1", s_tready, 1'b1);
      step(1'b1, 32'h84, 1'b0, 1'b1);
      check_eq("cont_w0", m_tdata, 64'h00000074_00000064);
      check_eq("cont_rdy2", s_tready, 1'b1);
      step(1'b1, 32'h94, 1'b0, 1'b1);
      check_eq("cont_rdy3", s_tready, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      check_eq("cont_w1", m_tdata, 64'h00000094_00000084);

      // Early tlast, then restart at lane 0
      step(1'b1, 32'hA4, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      check_eq("early_data", m_tdata, 64'h00000000_000000A4);
      check_eq("early_last", m_tlast, 1'b1);
`ifdef AXIS_UPSIZER_TKEEP_EN
      check_eq("early_keep", m_tkeep, 8'h0F);
`endif
      step(1'b1, 32'h05, 1'b0, 1'b1);
      step(1'b1, 32'h06, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      check_eq("restart_data", m_tdata, 64'h00000006_00000005);

      // Backpressure
      step(1'b1, 32'h11, 1'b0, 1'b1);
      step(1'b1, 32'h22, 1'b0, 1'b0);
      step(1'b1, 32'h33, 1'b0, 1'b0);
      check_eq("bp_rdy", s_tready, 1'b0);
      check_eq("bp_data0", m_tdata, 64'h00000022_00000011);
      step(1'b1, 32'h33, 1'b0, 1'b0);
      check_eq("bp_hold", m_tdata, 64'h00000022_00000011);
      step(1'b1, 32'h33, 1'b0, 1'b1);
      check_eq("bp_resume", s_tready, 1'b1);
      step(1'b1, 32'h44, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      check_eq("bp_word2", m_tdata, 64'h00000044_00000033);
      // Pending word is dropped by reset
      apply_reset();

      // Mid-packet reset
      step(1'b1, 32'h64, 1'b0, 1'b1);
      apply_reset();
      step(1'b1, 32'hB4, 1'b0, 1'b1);
      step(1'b1, 32'hC4, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      check_eq("mrst_data", m_tdata, 64'h000000C4_000000B4);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) apply_reset();
         step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) < 7);
      end
      step(1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      check_eq("drained", m_tvalid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
